// File: rtl/ysyx_22050039_cpu_ctrl.sv
// Multi-cycle sequencer for the ysyx_22050039 core: fetch handshake, instruction register,
// WB-only PC/regfile write gating, ebreak halt, and cycle/retired-instruction counters.
module ysyx_22050039_cpu_ctrl #(
    parameter int INST_LEN = 32,
    parameter int CNT_W    = 64
) (
    input  logic                i_clk,
    input  logic                i_rst,
    output logic                o_ifetch_req,
    input  logic                i_ifetch_ack,
    input  logic [INST_LEN-1:0] i_ifetch_rdata,
    output logic [INST_LEN-1:0] o_inst,
    input  logic                i_dec_mem_op,
    input  logic                i_dec_rf_we,
    input  logic                i_dec_ebreak,
    output logic                o_dmem_req,
    input  logic                i_dmem_ack,
    output logic                o_pc_wen,
    output logic                o_rf_wen,
    output logic                o_halted,
    output logic [2:0]          o_state,
    output logic [CNT_W-1:0]    o_cycle_cnt,
    output logic [CNT_W-1:0]    o_instret
);

    // state  | meaning
    // FETCH  | request instruction, latch it on ack
    // DECODE | IDU decodes the stable instruction register
    // EXEC   | EXU result and dnpc settle
    // MEM    | data access outstanding until ack
    // WB     | commit: pc and rd writes, retire
    // HALT   | stopped after ebreak until reset
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [INST_LEN-1:0] r_inst;
    logic [CNT_W-1:0]    r_cycle_cnt;
    logic [CNT_W-1:0]    r_instret;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_FETCH;
            r_inst      <= '0;
            r_cycle_cnt <= '0;
            r_instret   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && i_ifetch_ack)
                r_inst <= i_ifetch_rdata;
            if (r_state != S_HALT)
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            if (r_state == S_WB)
                r_instret <= r_instret + CNT_W'(1);
        end
    end

    // Acks are only looked at in the state that is waiting for them.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (i_ifetch_ack) w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC:   w_next = i_dec_mem_op ? S_MEM : S_WB;
            S_MEM:    if (i_dmem_ack) w_next = S_WB;
            S_WB:     w_next = i_dec_ebreak ? S_HALT : S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    assign o_ifetch_req = (r_state == S_FETCH);
    assign o_dmem_req   = (r_state == S_MEM);
    assign o_pc_wen     = (r_state == S_WB) && !i_dec_ebreak;
    assign o_rf_wen     = (r_state == S_WB) && i_dec_rf_we;
    assign o_halted     = (r_state == S_HALT);
    assign o_state      = r_state;
    assign o_inst       = r_inst;
    assign o_cycle_cnt  = r_cycle_cnt;
    assign o_instret    = r_instret;

endmodule

// File: tb/tb_ysyx_22050039_cpu_ctrl.sv
// Bench for ysyx_22050039_cpu_ctrl: per-instruction trace model (expected state sequence
// and cycle cost derived from fetch/mem wait counts), randomized waits and stray acks.
module tb_ysyx_22050039_cpu_ctrl;
    localparam int INST_LEN = 32;
    localparam int CNT_W    = 64;

    logic                i_clk = 1'b0;
    logic                i_rst = 1'b1;
    logic                o_ifetch_req;
    logic                i_ifetch_ack = 1'b0;
    logic [INST_LEN-1:0] i_ifetch_rdata = '0;
    logic [INST_LEN-1:0] o_inst;
    logic                i_dec_mem_op = 1'b0;
    logic                i_dec_rf_we = 1'b0;
    logic                i_dec_ebreak = 1'b0;
    logic                o_dmem_req;
    logic                i_dmem_ack = 1'b0;
    logic                o_pc_wen;
    logic                o_rf_wen;
    logic                o_halted;
    logic [2:0]          o_state;
    logic [CNT_W-1:0]    o_cycle_cnt;
    logic [CNT_W-1:0]    o_instret;

    ysyx_22050039_cpu_ctrl #(.INST_LEN(INST_LEN), .CNT_W(CNT_W)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .o_ifetch_req(o_ifetch_req), .i_ifetch_ack(i_ifetch_ack), .i_ifetch_rdata(i_ifetch_rdata),
        .o_inst(o_inst),
        .i_dec_mem_op(i_dec_mem_op), .i_dec_rf_we(i_dec_rf_we), .i_dec_ebreak(i_dec_ebreak),
        .o_dmem_req(o_dmem_req), .i_dmem_ack(i_dmem_ack),
        .o_pc_wen(o_pc_wen), .o_rf_wen(o_rf_wen), .o_halted(o_halted),
        .o_state(o_state), .o_cycle_cnt(o_cycle_cnt), .o_instret(o_instret)
    );

    always #5 i_clk = ~i_clk;

    int          n_checks = 0;
    int          n_errors = 0;
    longint      exp_cycles;
    longint      exp_instret;
    logic [31:0] prev_inst;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic stray_acks();
        i_ifetch_ack   = 1'($urandom_range(0, 1));
        i_dmem_ack     = 1'($urandom_range(0, 1));
        i_ifetch_rdata = $urandom;
    endtask

    task automatic check_idle_outputs(input string tag, input int st);
        chk({tag, ".state"}, 64'(o_state), 64'(st));
        chk({tag, ".ifetch_req"}, 64'(o_ifetch_req), 64'(st == 0));
        chk({tag, ".dmem_req"}, 64'(o_dmem_req), 64'(st == 3));
        chk({tag, ".pc_wen"}, 64'(o_pc_wen), 64'b0);
        chk({tag, ".rf_wen"}, 64'(o_rf_wen), 64'b0);
        chk({tag, ".halted"}, 64'(o_halted), 64'(st == 5));
    endtask

    // Reset with acks asserted and nonzero rdata in the reset cycle; all must be ignored.
    task automatic do_reset();
        i_rst          = 1'b1;
        i_ifetch_ack   = 1'b1;
        i_dmem_ack     = 1'b1;
        i_ifetch_rdata = $urandom | 32'h1;
        tick();
        i_rst = 1'b0;
        exp_cycles  = 0;
        exp_instret = 0;
        prev_inst   = '0;
        check_idle_outputs("rst", 0);
        chk("rst.inst", 64'(o_inst), 64'h0);
        chk("rst.cycle_cnt", o_cycle_cnt, 64'h0);
        chk("rst.instret", o_instret, 64'h0);
    endtask

    // One instruction: wf fetch wait cycles, optional MEM with wm wait cycles.
    task automatic run_inst(input int wf, input bit mem, input int wm, input bit rfwe,
                            input bit ebr, input logic [31:0] data);
        int len;
        i_dec_mem_op = mem;
        i_dec_rf_we  = rfwe;
        i_dec_ebreak = ebr;
        len = (wf + 1) + 1 + 1 + (mem ? wm + 1 : 0) + 1;
        for (int k = 0; k <= wf; k++) begin
            stray_acks();
            i_ifetch_ack = (k == wf);
            if (k == wf) i_ifetch_rdata = data;
            check_idle_outputs("fetch", 0);
            chk("fetch.inst_hold", 64'(o_inst), 64'(prev_inst));
            tick();
        end
        stray_acks();
        check_idle_outputs("decode", 1);
        chk("decode.inst", 64'(o_inst), 64'(data));
        tick();
        stray_acks();
        check_idle_outputs("exec", 2);
        chk("exec.inst", 64'(o_inst), 64'(data));
        tick();
        if (mem) begin
            for (int k = 0; k <= wm; k++) begin
                stray_acks();
                i_dmem_ack = (k == wm);
                check_idle_outputs("mem", 3);
                chk("mem.inst", 64'(o_inst), 64'(data));
                tick();
            end
        end
        stray_acks();
        chk("wb.state", 64'(o_state), 64'd4);
        chk("wb.pc_wen", 64'(o_pc_wen), 64'(!ebr));
        chk("wb.rf_wen", 64'(o_rf_wen), 64'(rfwe));
        chk("wb.reqs", 64'({o_ifetch_req, o_dmem_req}), 64'b0);
        chk("wb.inst", 64'(o_inst), 64'(data));
        tick();
        exp_cycles  += len;
        exp_instret += 1;
        prev_inst    = data;
        chk("inst.cycle_cnt", o_cycle_cnt, 64'(exp_cycles));
        chk("inst.instret", o_instret, 64'(exp_instret));
    endtask

    initial begin
        do_reset();

        // ALU stream, 1-cycle fetch acks: 10 instructions in 40 cycles.
        for (int i = 0; i < 10; i++) run_inst(0, 1'b0, 0, 1'b1, 1'b0, 32'h00000013 + 32'(i << 7));
        chk("alu.cycle_cnt40", o_cycle_cnt, 64'd40);
        chk("alu.instret10", o_instret, 64'd10);

        run_inst(3, 1'b0, 0, 1'b1, 1'b0, 32'h00100513);     // fetch wait
        run_inst(0, 1'b1, 2, 1'b1, 1'b0, 32'h00052583);     // load, 7 cycles
        run_inst(0, 1'b1, 0, 1'b0, 1'b0, 32'h00b52023);     // store
        for (int i = 0; i < 30; i++)
            run_inst($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), 1'b0, $urandom);

        // ebreak writing rd, then halt must be absorbing and freeze everything.
        run_inst(1, 1'b0, 0, 1'b1, 1'b1, 32'h00100073);
        for (int i = 0; i < 20; i++) begin
            stray_acks();
            i_dec_mem_op = 1'($urandom_range(0, 1));
            i_dec_rf_we  = 1'($urandom_range(0, 1));
            i_dec_ebreak = 1'($urandom_range(0, 1));
            check_idle_outputs("halt", 5);
            chk("halt.cycle_cnt", o_cycle_cnt, 64'(exp_cycles));
            chk("halt.instret", o_instret, 64'(exp_instret));
            chk("halt.inst", 64'(o_inst), 64'h00100073);
            tick();
        end

        // Out of HALT by reset; stray dmem_ack in DECODE; reset mid-MEM with ack.
        do_reset();
        i_dec_mem_op = 1'b1; i_dec_rf_we = 1'b1; i_dec_ebreak = 1'b0;
        i_ifetch_ack = 1'b1; i_ifetch_rdata = 32'h0000a503; i_dmem_ack = 1'b0;
        tick();
        i_ifetch_ack = 1'b0; i_dmem_ack = 1'b1;
        chk("stray.decode_state", 64'(o_state), 64'd1);
        tick();
        i_dmem_ack = 1'b0;
        chk("stray.exec_state", 64'(o_state), 64'd2);
        chk("stray.inst", 64'(o_inst), 64'h0000a503);
        tick();
        chk("midmem.state", 64'(o_state), 64'd3);
        chk("midmem.cycle_cnt", o_cycle_cnt, 64'd3);
        i_rst = 1'b1; i_dmem_ack = 1'b1;
        tick();
        i_rst = 1'b0; i_dmem_ack = 1'b0;
        check_idle_outputs("midmem_rst", 0);
        chk("midmem_rst.inst", 64'(o_inst), 64'h0);
        chk("midmem_rst.cycle_cnt", o_cycle_cnt, 64'h0);
        chk("midmem_rst.instret", o_instret, 64'h0);
        exp_cycles = 0; exp_instret = 0; prev_inst = '0;
        run_inst(0, 1'b0, 0, 1'b1, 1'b0, 32'h00100513);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
